hub75_row_capture: RTL

HUB75_ROW_CAPTURE -- requirements
Module: hub75_row_capture

---
 rtl/hub75_row_capture.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/hub75_row_capture.sv
// Captures one HUB75 row (six serial colour lanes plus address) into a parallel
// buffer with a valid/ready handshake; bus inputs are asynchronous to clk.
module hub75_row_capture #(
  parameter int COLS  = 64,
  parameter int CNT_W = 8,
  parameter int OE_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CLK_MOD,
  input  logic             LAT,
  input  logic             OE,
  input  logic             R1,
  input  logic             G1,
  input  logic             B1,
  input  logic             R2,
  input  logic             G2,
  input  logic             B2,
  input  logic             A,
  input  logic             B,
  output logic             row_valid,
  input  logic             row_ready,
  output logic [1:0]       row_addr,
  output logic [COLS-1:0]  top_r,
  output logic [COLS-1:0]  top_g,
  output logic [COLS-1:0]  top_b,
  output logic [COLS-1:0]  bot_r,
  output logic [COLS-1:0]  bot_g,
  output logic [COLS-1:0]  bot_b,
  output logic [CNT_W-1:0] bit_count,
  output logic [OE_W-1:0]  oe_cycles,
  output logic             len_err,
  output logic             overflow,
  input  logic             clr
);

  localparam int NPIN  = 11;
  localparam int P_CLK = 0;
  localparam int P_LAT = 1;
  localparam int P_OE  = 2;
  localparam int P_COL = 3;
  localparam int P_A   = 9;
  localparam int P_B   = 10;

  logic [NPIN-1:0]      pins;
  logic [NPIN-1:0]      sync1_q, sync1_d;
  logic [NPIN-1:0]      sync2_q, sync2_d;
  logic [NPIN-1:0]      dly_q, dly_d;
  logic                 clk_rise_q, clk_rise_d;
  logic                 lat_rise_q, lat_rise_d;
  logic [5:0][COLS-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d, bit_cnt_inc;
  logic [OE_W-1:0]      oe_cnt_q, oe_cnt_d, oe_cnt_inc;
  logic [5:0][COLS-1:0] data_q, data_d;
  logic [1:0]           addr_q, addr_d;
  logic [CNT_W-1:0]     bits_q, bits_d;
  logic [OE_W-1:0]      oe_q, oe_d;
  logic                 len_err_q, len_err_d;
  logic                 valid_q, valid_d;
  logic                 ovf_q, ovf_d;
  logic                 slot_free;
  logic                 load;

  assign pins = {B, A, B2, G2, R2, B1, G1, R1, OE, LAT, CLK_MOD};

  always_comb begin
    sync1_d = pins;
    sync2_d = sync1_q;
    // dly_q is the previous synchronised sample, and also lines the pin data up
    // with the registered edge pulses below.
    dly_d      = sync2_q;
    clk_rise_d = sync2_q[P_CLK] & ~dly_q[P_CLK];
    lat_rise_d = sync2_q[P_LAT] & ~dly_q[P_LAT];

    sr_d        = sr_q;
    bit_cnt_inc = bit_cnt_q;
    if (clk_rise_q) begin
      for (int i = 0; i < 6; i++) begin
        sr_d[i] = {sr_q[i][COLS-2:0], dly_q[P_COL+i]};
      end
      if (bit_cnt_q != '1) bit_cnt_inc = bit_cnt_q + CNT_W'(1);
    end

    oe_cnt_inc = oe_cnt_q;
    if (!dly_q[P_OE] && (oe_cnt_q != '1)) oe_cnt_inc = oe_cnt_q + OE_W'(1);

    bit_cnt_d = lat_rise_q ? '0 : bit_cnt_inc;
    oe_cnt_d  = lat_rise_q ? '0 : oe_cnt_inc;

    // A coincident shift and OE-low cycle belong to the row being latched.
    slot_free = ~valid_q | row_ready;
    load      = lat_rise_q & slot_free;

    data_d    = data_q;
    addr_d    = addr_q;
    bits_d    = bits_q;
    oe_d      = oe_q;
    len_err_d = len_err_q;
    if (load) begin
      data_d    = sr_d;
      addr_d    = {dly_q[P_B], dly_q[P_A]};
      bits_d    = bit_cnt_inc;
      oe_d      = oe_cnt_inc;
      len_err_d = (bit_cnt_inc != CNT_W'(COLS));
    end

    valid_d = load | (valid_q & ~row_ready);
    ovf_d   = (lat_rise_q & ~slot_free) | (ovf_q & ~clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      dly_q      <= '0;
      clk_rise_q <= 1'b0;
      lat_rise_q <= 1'b0;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      oe_cnt_q   <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      bits_q     <= '0;
      oe_q       <= '0;
      len_err_q  <= 1'b0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      dly_q      <= dly_d;
      clk_rise_q <= clk_rise_d;
      lat_rise_q <= lat_rise_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      oe_cnt_q   <= oe_cnt_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      bits_q     <= bits_d;
      oe_q       <= oe_d;
      len_err_q  <= len_err_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign row_valid = valid_q;
  assign row_addr  = addr_q;
  assign top_r     = data_q[0];
  assign top_g     = data_q[1];
  assign top_b     = data_q[2];
  assign bot_r     = data_q[3];
  assign bot_g     = data_q[4];
  assign bot_b     = data_q[5];
  assign bit_count = bits_q;
  assign oe_cycles = oe_q;
  assign len_err   = len_err_q;
  assign overflow  = ovf_q;

endmodule
